// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: drives the ALU for the decode stage and returns its result.
//
// Takes decoded instruction fields and register data over a valid/ready
// handshake and encodes the ALU control code and operands into registered
// alu_* outputs. It holds those outputs for SETTLE_CYCLES and then captures
// the ALU result and zero flag. The captured values go back over a second
// valid/ready handshake, together with branch-taken and illegal flags.
//
// Ports:
//   clk_i, rst_i         clock; synchronous active-high reset
//   req_valid_i/ready_o  request handshake from decode
//   req_op_i, req_funct_i, req_shamt_i, req_imm_i  instruction fields
//   req_rs_i, req_rt_i   register operands
//   alu_src1_o, alu_src2_o, alu_ctrl_o             registered ALU inputs
//   alu_result_i, alu_zero_i                       ALU outputs
//   rsp_valid_o/ready_i  response handshake toward writeback / PC logic
//   rsp_result_o, rsp_zero_o, rsp_branch_o, rsp_illegal_o  captured response
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request; alu_* hold the last issued operation
// DRIVE  | alu_* held stable while the ALU settles; counter runs
// RESP   | rsp_* valid and frozen until the consumer takes them
module alu_issue_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [5:0]  req_op_i,
  input  logic [5:0]  req_funct_i,
  input  logic [4:0]  req_shamt_i,
  input  logic [15:0] req_imm_i,
  input  logic [31:0] req_rs_i,
  input  logic [31:0] req_rt_i,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [3:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_zero_o,
  output logic        rsp_branch_o,
  output logic        rsp_illegal_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_branch_q;

  logic              accept;
  logic              capture;

  logic              dec_legal;
  logic              dec_branch;
  logic [3:0]        dec_ctrl;
  logic [31:0]       dec_src1;
  logic [31:0]       dec_src2;
  logic [31:0]       imm_sext;
  logic [31:0]       imm_zext;

  assign req_ready_o = (state_q == S_IDLE) && !rst_i;
  assign rsp_valid_o = (state_q == S_RESP);
  assign accept      = req_valid_i && req_ready_o;
  assign capture     = (state_q == S_DRIVE) && (cnt_q == CNT_LAST);

  assign imm_sext = {{16{req_imm_i[15]}}, req_imm_i};
  assign imm_zext = {16'b0, req_imm_i};

  // Instruction decode into ALU control code and operand packing.
  always_comb begin
    dec_legal  = 1'b1;
    dec_branch = 1'b0;
    dec_ctrl   = 4'd0;
    dec_src1   = req_rs_i;
    dec_src2   = req_rt_i;
    case (req_op_i)
      6'h00: begin
        case (req_funct_i)
          6'h24: dec_ctrl = 4'd0;
          6'h25: dec_ctrl = 4'd1;
          6'h20: dec_ctrl = 4'd2;
          6'h22: dec_ctrl = 4'd6;
          6'h2A: dec_ctrl = 4'd4;
          6'h03: begin
            // The ALU takes the shift amount from src1[10:6].
            dec_ctrl = 4'd8;
            dec_src1 = {21'b0, req_shamt_i, 6'b0};
          end
          6'h07: dec_ctrl = 4'd9;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08: begin
        dec_ctrl = 4'd2;
        dec_src2 = imm_sext;
      end
      6'h0D: begin
        dec_ctrl = 4'd1;
        dec_src2 = imm_zext;
      end
      6'h0A: begin
        dec_ctrl = 4'd3;
        dec_src2 = imm_sext;
      end
      6'h04: begin
        dec_ctrl   = 4'd7;
        dec_branch = 1'b1;
      end
      6'h05: begin
        dec_ctrl   = 4'd10;
        dec_branch = 1'b1;
      end
      6'h0F: begin
        dec_ctrl = 4'd11;
        dec_src1 = 32'd0;
        dec_src2 = imm_zext;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = dec_legal ? S_DRIVE : S_RESP;
        end
      end
      S_DRIVE: begin
        if (capture) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q == S_DRIVE) begin
      cnt_q <= capture ? '0 : cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alu_src1_o    <= 32'd0;
      alu_src2_o    <= 32'd0;
      alu_ctrl_o    <= 4'd0;
      is_branch_q   <= 1'b0;
      rsp_result_o  <= 32'd0;
      rsp_zero_o    <= 1'b0;
      rsp_branch_o  <= 1'b0;
      rsp_illegal_o <= 1'b0;
    end else begin
      if (accept && dec_legal) begin
        alu_src1_o  <= dec_src1;
        alu_src2_o  <= dec_src2;
        alu_ctrl_o  <= dec_ctrl;
        is_branch_q <= dec_branch;
      end
      // Illegal requests skip the ALU; alu_* keep the previous operation.
      if (accept && !dec_legal) begin
        rsp_result_o  <= 32'd0;
        rsp_zero_o    <= 1'b0;
        rsp_branch_o  <= 1'b0;
        rsp_illegal_o <= 1'b1;
      end
      if (capture) begin
        rsp_result_o  <= alu_result_i;
        rsp_zero_o    <= alu_zero_i;
        rsp_branch_o  <= is_branch_q && alu_zero_i;
        rsp_illegal_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU operand/control interface.
- Accepts decoded instruction fields and register data from the decode stage over a valid/ready handshake.
- Encodes the 4-bit ALU control code and packs src1/src2 as the ALU expects, then drives the ALU and waits a programmable settle time.
- Captures result/zero and returns them, with a branch-taken flag, over a second valid/ready handshake toward writeback/PC logic.

Parameters:
- SETTLE_CYCLES, 1: cycles ALU inputs are held stable before result capture; legal range 1..15.
- CNT_W, 4: width of the settle counter.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request accepted when high with req_valid_i.
- req_op_i  input  6  instruction opcode [31:26].
- req_funct_i  input  6  instruction funct [5:0].
- req_shamt_i  input  5  instruction shamt [10:6].
- req_imm_i  input  16  instruction immediate [15:0].
- req_rs_i  input  32  rs register data.
- req_rt_i  input  32  rt register data.
- alu_src1_o  output  32  ALU operand 1.
- alu_src2_o  output  32  ALU operand 2.
- alu_ctrl_o  output  4  ALU control code.
- alu_result_i  input  32  ALU result.
- alu_zero_i  input  1  ALU zero flag.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  consumer ready.
- rsp_result_o  output  32  captured result.
- rsp_zero_o  output  1  captured zero flag.
- rsp_branch_o  output  1  branch taken (beq/bne only).
- rsp_illegal_o  output  1  unsupported op/funct.

Behaviour:
- Reset (rst_i=1 at edge): state IDLE, counter 0, every registered output 0. req_ready_o is forced 0 while rst_i=1. Reset mid-transaction discards it without a response.
- States:
  - IDLE: req_ready_o=1. On req_valid_i&req_ready_o, latch fields and encode. Legal op -> DRIVE. Illegal op -> RESP.
  - DRIVE: alu_* held stable and counter increments. When counter==SETTLE_CYCLES-1, capture alu_result_i/alu_zero_i into rsp_* regs and go to RESP.
  - RESP: rsp_valid_o=1 with all rsp_* stable. On rsp_ready_i -> IDLE. No new accept in the same cycle.
- Latency: accept at edge N. Result captured at edge N+SETTLE_CYCLES. rsp_valid_o high from cycle N+SETTLE_CYCLES+1.
- Throughput: one request per SETTLE_CYCLES+2 cycles with rsp_ready_i tied high.
- Encoding, as (op, funct) -> ctrl, src1, src2:
  - R-type (op=0x00):
    - 0x24 and -> 0, rs, rt
    - 0x25 or -> 1, rs, rt
    - 0x20 add -> 2, rs, rt
    - 0x22 sub -> 6, rs, rt
    - 0x2A slt -> 4, rs, rt
    - 0x03 sra -> 8, {21'b0, shamt, 6'b0}, rt
    - 0x07 srav -> 9, rs, rt
  - I-type:
    - 0x08 addi -> 2, rs, sign-extended imm
    - 0x0D ori -> 1, rs, zero-extended imm
    - 0x0A slti -> 3, rs, sign-extended imm (the ALU zero-extends internally)
    - 0x04 beq -> 7, rs, rt
    - 0x05 bne -> 10, rs, rt
    - 0x0F lui -> 11, 0, {16'b0, imm}
- rsp_branch_o = alu_zero_i captured for beq/bne; 0 for all other ops.
- Illegal op/funct: alu_* unchanged, rsp_result_o=0, rsp_zero_o=0, rsp_branch_o=0, rsp_illegal_o=1, RESP entered one cycle after accept.
- alu_* outputs are registered, hold their last value in IDLE/RESP, and update only on accept.
- rsp_* registers update only at capture (or the illegal path) and hold through any number of rsp_ready_i=0 cycles.
- req_valid_i in DRIVE/RESP is ignored (req_ready_o=0).

Test Plan:
- Reset: rst_i=1 for 2 cycles with req_valid_i=1 -> req_ready_o=0, rsp_valid_o=0, all outputs 0. Cycle after release -> req_ready_o=1.
- add, SETTLE=1: op=0, funct=0x20, rs=5, rt=7, ALU model returns 12 -> alu_ctrl_o=2, src1=5, src2=7. rsp_valid_o exactly 2 cycles after accept; rsp_result_o=12, rsp_zero_o=0, rsp_illegal_o=0.
- beq taken: op=0x04, rs=rt=0x1234, ALU returns 0 with zero=1 -> ctrl=7, rsp_branch_o=1. Same test with bne (op=0x05) -> ctrl=10, rsp_branch_o=1 only when rs!=rt.
- sra packing: funct=0x03, shamt=4, rt=0x80000000 -> src1=0x00000100, ctrl=8, rsp_result_o=0xF8000000 from the ALU model.
- Back-pressure: hold rsp_ready_i=0 for 5 cycles after rsp_valid_o rises -> rsp_* constant and req_ready_o=0 throughout. rsp_ready_i=1 -> IDLE next cycle.
- Illegal and reset mid-op:
  - op=0x3F -> rsp_illegal_o=1, rsp_result_o=0, rsp_valid_o 1 cycle after accept.
  - SETTLE=3 with rst_i asserted in the second DRIVE cycle -> IDLE, no response, outputs 0.
